// File: rtl/lsu_subword.sv
// lsu_subword: RV32I load/store unit in front of a word-only data RAM.
// Ports: req_* from the core, rsp_* back to it, mem_* to the combinational-read RAM.
module lsu_subword #(
  parameter logic [31:0] RAM_LIMIT = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_range;
  logic        w_err;
  logic        w_sub_st;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_is_byte = (r_funct3[1:0] == 2'b00);
  assign w_is_half = (r_funct3[1:0] == 2'b01);
  assign w_is_word = (r_funct3 == 3'b010);

  // Stores have no unsigned forms, so only 000/001/010 are legal.
  assign w_f3_ok = r_we
    ? (r_funct3[2] == 1'b0 && r_funct3[1:0] != 2'b11)
    : (r_funct3 != 3'b011 && r_funct3[2:1] != 2'b11);

  assign w_misalign = (w_is_half && r_addr[0])
                   || (w_is_word && r_addr[1:0] != 2'b00);
  assign w_range    = (r_addr >= RAM_LIMIT);
  assign w_err      = !w_f3_ok || w_misalign || w_range;
  assign w_sub_st   = r_we && (w_is_byte || w_is_half);

  always_comb begin
    w_byte = mem_data_out[7:0];
    unique case (r_addr[1:0])
      2'b00: w_byte = mem_data_out[7:0];
      2'b01: w_byte = mem_data_out[15:8];
      2'b10: w_byte = mem_data_out[23:16];
      2'b11: w_byte = mem_data_out[31:24];
    endcase
  end

  assign w_half = r_addr[1] ? mem_data_out[31:16]
                            : mem_data_out[15:0];

  // funct3[2] set means the unsigned (zero-extending) form.
  always_comb begin
    w_load = '0;
    unique case (1'b1)
      w_is_word: w_load = mem_data_out;
      w_is_half: w_load = {{16{~r_funct3[2] & w_half[15]}}, w_half};
      default:   w_load = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
    endcase
  end

  always_comb begin
    w_merge = mem_data_out;
    if (w_is_half) begin
      if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
      else           w_merge[15:0]  = r_wdata[15:0];
    end else begin
      unique case (r_addr[1:0])
        2'b00: w_merge[7:0]   = r_wdata[7:0];
        2'b01: w_merge[15:8]  = r_wdata[7:0];
        2'b10: w_merge[23:16] = r_wdata[7:0];
        2'b11: w_merge[31:24] = r_wdata[7:0];
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign mem_address = {r_addr[31:2], 2'b00};

  // mem_we decodes straight from state so an async reset drops it at once.
  always_comb begin
    w_next      = r_state;
    mem_we      = 1'b0;
    mem_data_in = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        mem_we = r_we && w_is_word && !w_err;
        w_next = (w_sub_st && !w_err) ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        mem_we      = 1'b1;
        mem_data_in = r_merge;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_funct3  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_merge   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      r_state   <= w_next;
      rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
          end
        end
        S_EXEC: begin
          if (w_err) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
          end else if (!r_we) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= w_load;
          end else if (w_is_word) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            r_merge <= w_merge;
          end
        end
        S_WRITE: begin
          rsp_valid <= 1'b1;
          rsp_error <= 1'b0;
          rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: scoreboard bench for lsu_subword with a word RAM model.
// Ports: drives req_*, models the RAM on mem_*, checks rsp_* and mem_we timing.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_val;
    else if (mem_we) ram[mem_address[10:2]] <= mem_data_in;
  end

  assign mem_data_out = ram[mem_address[10:2]];

  lsu_subword dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wec;
    int          wcy;
    logic        chk;
    int          idx;
    logic [31:0] mv;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wec;
    int          wcy;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wec;
    int          wcy;
    logic        rdy0;
    logic        rdy1;
  } obs_t;

  exp_t sb[$];

  function automatic vec_t mkv(
    input string nm, input logic we, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rd, input logic er,
    input int lat, input int wec, input int wcy,
    input logic chk, input int idx, input logic [31:0] mv);
    vec_t v;
    v.nm = nm; v.we = we; v.f3 = f3; v.a = a; v.wd = wd;
    v.rd = rd; v.er = er; v.lat = lat; v.wec = wec;
    v.wcy = wcy; v.chk = chk; v.idx = idx; v.mv = mv;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.rdata = v.rd; e.err = v.er; e.lat = v.lat;
    e.wec = v.wec; e.wcy = v.wcy;
    return e;
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_idx = idx[8:0];
    pl_val = val;
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Drives one request and observes the DUT until rsp_valid (bounded).
  task automatic issue(input vec_t v, output obs_t o);
    o.rdata = '0; o.err = 1'b0; o.lat = 99;
    o.wec = 0; o.wcy = 0; o.rdy0 = 1'b0; o.rdy1 = 1'b1;
    sb.push_back(to_exp(v));
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.a;
    req_wdata  = v.wd;
    o.rdy0     = req_ready;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    o.rdy1     = req_ready;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we === 1'b1) begin
        o.wec++;
        o.wcy = c;
      end
      if (rsp_valid === 1'b1) begin
        o.lat   = c;
        o.rdata = rsp_rdata;
        o.err   = rsp_error;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rsp: valid=%b err=%b, want 0 0",
               rsp_valid, rsp_error);
    end
    n_vec++;
    if (rsp_rdata !== 32'h0 || mem_data_in !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h din=%h, want 0 0",
               rsp_rdata, mem_data_in);
    end
    n_vec++;
    if (mem_we !== 1'b0 || mem_address !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mem: we=%b addr=%h, want 0 0",
               mem_we, mem_address);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, want 1", req_ready);
    end
  endtask

  task automatic test_loads();
    vec_t v[$];
    obs_t o;
    exp_t e;
    preload(4, 32'h8899AABB);
    preload(511, 32'h13579BDF);
    v.push_back(mkv("LB", 0, 3'b000, 32'h11, 0, 32'hFFFFFFAA,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("LBU", 0, 3'b100, 32'h11, 0, 32'h000000AA,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("LH", 0, 3'b001, 32'h12, 0, 32'hFFFF8899,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("LHU", 0, 3'b101, 32'h12, 0, 32'h00008899,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("LW", 0, 3'b010, 32'h10, 0, 32'h8899AABB,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("LB0", 0, 3'b000, 32'h10, 0, 32'hFFFFFFBB,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("LBU3", 0, 3'b100, 32'h13, 0, 32'h00000088,
                    0, 2, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      issue(v[i], o);
      e = sb.pop_front();
      n_vec++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        n_err++;
        $display("FAIL %s rsp: rdata=%h err=%b, want %h %b",
                 v[i].nm, o.rdata, o.err, e.rdata, e.err);
      end
      n_vec++;
      if (o.lat != e.lat || o.wec != e.wec) begin
        n_err++;
        $display("FAIL %s timing: lat=%0d we=%0d, want %0d %0d",
                 v[i].nm, o.lat, o.wec, e.lat, e.wec);
      end
    end
  endtask

  task automatic test_stores();
    vec_t v[$];
    obs_t o;
    exp_t e;
    v.push_back(mkv("SB", 1, 3'b000, 32'h12, 32'h12345655, 0,
                    0, 3, 1, 2, 1, 4, 32'h8855AABB));
    v.push_back(mkv("SH", 1, 3'b001, 32'h10, 32'h0000CAFE, 0,
                    0, 3, 1, 2, 1, 4, 32'h8899CAFE));
    v.push_back(mkv("SHhi", 1, 3'b001, 32'h12, 32'h7777BEAD, 0,
                    0, 3, 1, 2, 1, 4, 32'hBEADAABB));
    v.push_back(mkv("SW", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0,
                    0, 2, 1, 1, 1, 4, 32'hDEADBEEF));
    foreach (v[i]) begin
      preload(4, 32'h8899AABB);
      issue(v[i], o);
      e = sb.pop_front();
      n_vec++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        n_err++;
        $display("FAIL %s rsp: rdata=%h err=%b, want %h %b",
                 v[i].nm, o.rdata, o.err, e.rdata, e.err);
      end
      n_vec++;
      if (o.lat != e.lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d, want %0d",
                 v[i].nm, o.lat, e.lat);
      end
      n_vec++;
      if (o.wec != e.wec || o.wcy != e.wcy) begin
        n_err++;
        $display("FAIL %s mem_we: cnt=%0d cyc=%0d, want %0d %0d",
                 v[i].nm, o.wec, o.wcy, e.wec, e.wcy);
      end
      n_vec++;
      if (ram[v[i].idx] !== v[i].mv) begin
        n_err++;
        $display("FAIL %s ram: got %h, want %h",
                 v[i].nm, ram[v[i].idx], v[i].mv);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[$];
    obs_t o;
    exp_t e;
    preload(4, 32'h8899AABB);
    preload(0, 32'hA5A5A5A5);
    v.push_back(mkv("LHmis", 0, 3'b001, 32'h13, 0, 0,
                    1, 2, 0, 0, 1, 4, 32'h8899AABB));
    v.push_back(mkv("LWmis", 0, 3'b010, 32'h12, 0, 0,
                    1, 2, 0, 0, 1, 4, 32'h8899AABB));
    v.push_back(mkv("SWmis", 1, 3'b010, 32'h11, 32'h11111111, 0,
                    1, 2, 0, 0, 1, 4, 32'h8899AABB));
    v.push_back(mkv("SHmis", 1, 3'b001, 32'h11, 32'h2222, 0,
                    1, 2, 0, 0, 1, 4, 32'h8899AABB));
    v.push_back(mkv("Lf3_011", 0, 3'b011, 32'h10, 0, 0,
                    1, 2, 0, 0, 1, 4, 32'h8899AABB));
    v.push_back(mkv("Sf3_100", 1, 3'b100, 32'h10, 32'h33, 0,
                    1, 2, 0, 0, 1, 4, 32'h8899AABB));
    v.push_back(mkv("LW800", 0, 3'b010, 32'h800, 0, 0,
                    1, 2, 0, 0, 1, 0, 32'hA5A5A5A5));
    v.push_back(mkv("SW800", 1, 3'b010, 32'h800, 32'h44444444, 0,
                    1, 2, 0, 0, 1, 0, 32'hA5A5A5A5));
    v.push_back(mkv("SB800", 1, 3'b000, 32'h801, 32'h55, 0,
                    1, 2, 0, 0, 1, 0, 32'hA5A5A5A5));
    v.push_back(mkv("LW7FC", 0, 3'b010, 32'h7FC, 0, 32'h13579BDF,
                    0, 2, 0, 0, 1, 511, 32'h13579BDF));
    foreach (v[i]) begin
      issue(v[i], o);
      e = sb.pop_front();
      n_vec++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        n_err++;
        $display("FAIL %s rsp: rdata=%h err=%b, want %h %b",
                 v[i].nm, o.rdata, o.err, e.rdata, e.err);
      end
      n_vec++;
      if (o.lat != e.lat || o.wec != e.wec) begin
        n_err++;
        $display("FAIL %s timing: lat=%0d we=%0d, want %0d %0d",
                 v[i].nm, o.lat, o.wec, e.lat, e.wec);
      end
      n_vec++;
      if (ram[v[i].idx] !== v[i].mv) begin
        n_err++;
        $display("FAIL %s ram: got %h, want %h",
                 v[i].nm, ram[v[i].idx], v[i].mv);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    obs_t o;
    exp_t e;
    preload(4, 32'h8899AABB);
    v.push_back(mkv("b2b_LBU", 0, 3'b100, 32'h13, 0, 32'h88,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("b2b_SB", 1, 3'b000, 32'h10, 32'hFFFFFF77, 0,
                    0, 3, 1, 2, 1, 4, 32'h8899AA77));
    v.push_back(mkv("b2b_LW", 0, 3'b010, 32'h10, 0, 32'h8899AA77,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("b2b_SW", 1, 3'b010, 32'h14, 32'h0BADF00D, 0,
                    0, 2, 1, 1, 1, 5, 32'h0BADF00D));
    v.push_back(mkv("b2b_LH", 0, 3'b001, 32'h14, 0, 32'hFFFFF00D,
                    0, 2, 0, 0, 0, 0, 0));
    v.push_back(mkv("b2b_LHU", 0, 3'b101, 32'h16, 0, 32'h00000BAD,
                    0, 2, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      issue(v[i], o);
      e = sb.pop_front();
      n_vec++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        n_err++;
        $display("FAIL %s rsp: rdata=%h err=%b, want %h %b",
                 v[i].nm, o.rdata, o.err, e.rdata, e.err);
      end
      n_vec++;
      if (o.lat != e.lat || o.wec != e.wec || o.wcy != e.wcy) begin
        n_err++;
        $display("FAIL %s timing: lat=%0d we=%0d@%0d, want %0d %0d@%0d",
                 v[i].nm, o.lat, o.wec, o.wcy, e.lat, e.wec, e.wcy);
      end
      n_vec++;
      if (o.rdy0 !== 1'b1 || o.rdy1 !== 1'b0) begin
        n_err++;
        $display("FAIL %s ready: idle=%b exec=%b, want 1 0",
                 v[i].nm, o.rdy0, o.rdy1);
      end
      if (v[i].chk) begin
        n_vec++;
        if (ram[v[i].idx] !== v[i].mv) begin
          n_err++;
          $display("FAIL %s ram: got %h, want %h",
                   v[i].nm, ram[v[i].idx], v[i].mv);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    int   seen;
    preload(4, 32'h8899AABB);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h12;
    req_wdata  = 32'h12345655;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_write: mem_we=%b, want 1", mem_we);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_drop: we=%b valid=%b, want 0 0",
               mem_we, rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || mem_we === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rstmid_quiet: activity=%0d, want 0", seen);
    end
    n_vec++;
    if (ram[4] !== 32'h8899AABB) begin
      n_err++;
      $display("FAIL rstmid_ram: got %h, want 8899aabb", ram[4]);
    end
    n_vec++;
    if (req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_idle: ready=%b rdata=%h, want 1 0",
               req_ready, rsp_rdata);
    end
    issue(mkv("rst_LW", 0, 3'b010, 32'h10, 0, 32'h8899AABB,
              0, 2, 0, 0, 0, 0, 0), o);
    e = sb.pop_front();
    n_vec++;
    if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
      n_err++;
      $display("FAIL rst_LW: rdata=%h err=%b lat=%0d, want %h %b %0d",
               o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the core's memory stage and the word-only data RAM.
- The data RAM has a combinational read, a synchronous write, word addressing and no byte enables.
- This block turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores are done as read-modify-write.
- It extracts and extends load data, and flags misaligned, illegal-width and out-of-range accesses without touching memory.

Parameters:
- RAM_LIMIT, 32'h00000800: first byte address outside data RAM. Any access with addr >= RAM_LIMIT is an error.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept; high only in IDLE
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I width/sign encoding
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/half used for SB/SH
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_error  output  1  valid with rsp_valid; misaligned, illegal funct3 or out of range
- mem_address  output  32  to RAM address; always {addr[31:2],2'b00}
- mem_data_in  output  32  to RAM write data
- mem_we  output  1  to RAM write enable
- mem_data_out  input  32  from RAM combinational read data

Behaviour:
- Reset (async): state=IDLE; all output registers are 0: rsp_valid, rsp_rdata, rsp_error, mem_we, mem_data_in, mem_address. Latched request fields are cleared.
- req_ready = (state==IDLE).
- A request is accepted when req_valid && req_ready. On accept, latch we/funct3/addr/wdata and go to EXEC.
- funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other values are illegal.
- funct3 for stores: 000 SB, 001 SH, 010 SW; all other values are illegal.
- Error condition, evaluated in EXEC:
  - illegal funct3, or
  - halfword with addr[0]!=0, or
  - word with addr[1:0]!=0, or
  - addr >= RAM_LIMIT.
  - On error: mem_we stays 0, go to IDLE, rsp_valid=1, rsp_error=1, rsp_rdata=0.
- EXEC, load:
  - Select from mem_data_out: byte = lane addr[1:0]; half = lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into rsp_rdata and go to IDLE with rsp_valid=1.
- EXEC, SW: mem_we=1, mem_data_in=wdata for exactly this cycle; go to IDLE with rsp_valid=1, rsp_rdata=0.
- EXEC, SB/SH:
  - mem_we=0.
  - Merge into a register: mem_data_out with the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - Go to WRITE.
- WRITE: mem_we=1, mem_data_in=merge register for exactly one cycle; go to IDLE with rsp_valid=1.
- Latency, counted from the accept edge to the rsp_valid cycle: loads and SW 2 cycles; SB/SH 3 cycles; errors 2 cycles.
- rsp_valid is high in the first IDLE cycle after completion. req_ready is also high in that cycle, so a back-to-back accept is legal in it.
- Throughput is 1 request per 2 cycles (3 for SB/SH).
- mem_we is never high in IDLE, and is never high for more than one cycle per request.
- mem_address is held stable through EXEC and WRITE.
- rsp_rdata/rsp_error hold their value until the next response. Only rsp_valid qualifies them.
- Reset mid-operation (EXEC or WRITE): the request is dropped, no response is issued, and mem_we deasserts immediately. A partial RMW write never occurs.
- Requests with req_valid low are ignored. Inputs are don't-care outside the accept cycle.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB 0x11 -> rsp_rdata=0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB. Each has rsp_error=0 and rsp_valid 2 cycles after accept.
- SB 0x12, wdata=0x12345655 -> mem_we high exactly one cycle, 2 cycles after accept. Word 0x10 becomes 0x8855AABB. rsp_valid 3 cycles after accept.
- SH 0x10, wdata=0x0000CAFE -> word 0x8899CAFE. SW 0x10, wdata=0xDEADBEEF -> word 0xDEADBEEF after 1 write cycle.
- LH 0x13, LW 0x12, SW 0x11, funct3=011 load -> rsp_error=1, rsp_rdata=0, mem_we never asserted, memory unchanged.
- LW 0x800 and SW 0x800 -> rsp_error=1, no write. LW 0x7FC -> returns the preloaded value with no error.
- Assert rst in the WRITE state of an SB -> mem_we low at once, memory unchanged, no rsp_valid. req_ready=1 after release, and the next LW completes normally.
